// File: rtl/lpm_route_engine.sv
// lpm_route_engine: 3-stage longest-prefix-match route lookup with valid/ready on both sides.
// Define ROUTE_ENGINE_STATS_EN to add saturating lookup/hit/default-hit counters.
module lpm_route_engine #(
    parameter int MAX_ENTRIES = 64,
    parameter int IDX_W       = $clog2(MAX_ENTRIES),
    parameter int ENTRY_WIDTH = 256,
    parameter int TAG_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_wr_en,
    output logic                   cfg_wr_ready,
    input  logic [IDX_W-1:0]       cfg_wr_addr,
    input  logic [ENTRY_WIDTH-1:0] cfg_wr_data,
    input  logic                   lookup_valid,
    output logic                   lookup_ready,
    input  logic [31:0]            lookup_dst_ip,
    input  logic [TAG_W-1:0]       lookup_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [TAG_W-1:0]       resp_tag,
    output logic                   resp_found,
    output logic [IDX_W-1:0]       resp_idx,
    output logic [15:0]            resp_out_port,
    output logic [15:0]            resp_out_qp,
    output logic [31:0]            resp_next_hop_ip,
    output logic [15:0]            resp_next_hop_port,
    output logic [15:0]            resp_next_hop_qp,
    output logic [47:0]            resp_next_hop_mac,
    output logic                   resp_is_direct_host,
    output logic                   resp_is_broadcast
`ifdef ROUTE_ENGINE_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_default_hits
`endif
);

    // Payload keeps entry[207:64] plus the two flag bits: {fields, bcast, direct}
    localparam int PAY_W = 146;

    logic [MAX_ENTRIES-1:0] vld_q;
    logic [31:0]            key_q  [MAX_ENTRIES];
    logic [5:0]             plen_q [MAX_ENTRIES];
    logic [PAY_W-1:0]       pay_q  [MAX_ENTRIES];

    logic                   s1_v_q;
    logic [31:0]            s1_ip_q;
    logic [TAG_W-1:0]       s1_tag_q;
    logic                   s2_v_q;
    logic                   s2_found_q;
    logic [IDX_W-1:0]       s2_idx_q;
    logic [TAG_W-1:0]       s2_tag_q;
    logic                   rsp_v_q;
    logic                   rsp_found_q;
    logic [IDX_W-1:0]       rsp_idx_q;
    logic [TAG_W-1:0]       rsp_tag_q;
    logic [PAY_W-1:0]       rsp_pay_q;

    logic                   stall;
    logic                   adv1;
    logic                   adv2;
    logic                   acc;
    logic                   wr_fire;
    logic [5:0]             wr_plen;
    logic                   hit_found;
    logic [IDX_W-1:0]       hit_idx;
    logic [5:0]             hit_len;
    logic                   unused_cfg_bits;

    function automatic logic [31:0] pfx_mask(input logic [5:0] plen);
        if (plen == 6'd0) return 32'h0;
        return 32'hFFFF_FFFF << (6'd32 - plen);
    endfunction

    // A stage may refill during a stall when it or its successor is a bubble
    assign stall        = rsp_v_q && !resp_ready;
    assign adv2         = !stall || !s2_v_q;
    assign adv1         = adv2 || !s1_v_q;
    assign lookup_ready = !stall && !cfg_wr_en;
    assign acc          = lookup_valid && lookup_ready;
    assign cfg_wr_ready = !s1_v_q && !s2_v_q && !rsp_v_q;
    assign wr_fire      = cfg_wr_en && cfg_wr_ready;
    assign wr_plen      = (cfg_wr_data[61:56] > 6'd32) ? 6'd32 : cfg_wr_data[61:56];
    assign unused_cfg_bits = ^cfg_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (wr_fire) begin
            vld_q[cfg_wr_addr] <= cfg_wr_data[32];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            key_q[cfg_wr_addr]  <= cfg_wr_data[31:0];
            plen_q[cfg_wr_addr] <= wr_plen;
            pay_q[cfg_wr_addr]  <= {cfg_wr_data[207:64], cfg_wr_data[48], cfg_wr_data[40]};
        end
    end

    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        hit_len   = '0;
        for (int e = 0; e < MAX_ENTRIES; e++) begin
            if (vld_q[e]
                && (((s1_ip_q ^ key_q[e]) & pfx_mask(plen_q[e])) == 32'h0)
                && (!hit_found || plen_q[e] > hit_len)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(e);
                hit_len   = plen_q[e];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_ip_q     <= '0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_found_q  <= 1'b0;
            s2_idx_q    <= '0;
            s2_tag_q    <= '0;
            rsp_v_q     <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_pay_q   <= '0;
        end else begin
            if (adv1) begin
                s1_v_q   <= acc;
                s1_ip_q  <= lookup_dst_ip;
                s1_tag_q <= lookup_tag;
            end
            if (adv2) begin
                s2_v_q     <= s1_v_q;
                s2_found_q <= hit_found;
                s2_idx_q   <= hit_idx;
                s2_tag_q   <= s1_tag_q;
            end
            if (!stall) begin
                rsp_v_q     <= s2_v_q;
                rsp_found_q <= s2_found_q;
                rsp_idx_q   <= s2_found_q ? s2_idx_q : '0;
                rsp_tag_q   <= s2_tag_q;
                rsp_pay_q   <= s2_found_q ? pay_q[s2_idx_q] : '0;
            end
        end
    end

    assign resp_valid          = rsp_v_q;
    assign resp_tag            = rsp_tag_q;
    assign resp_found          = rsp_found_q;
    assign resp_idx            = rsp_idx_q;
    assign resp_is_direct_host = rsp_pay_q[0];
    assign resp_is_broadcast   = rsp_pay_q[1];
    assign resp_out_port       = rsp_pay_q[17:2];
    assign resp_out_qp         = rsp_pay_q[33:18];
    assign resp_next_hop_ip    = rsp_pay_q[65:34];
    assign resp_next_hop_port  = rsp_pay_q[81:66];
    assign resp_next_hop_qp    = rsp_pay_q[97:82];
    assign resp_next_hop_mac   = rsp_pay_q[145:98];

`ifdef ROUTE_ENGINE_STATS_EN
    logic        rsp_dflt_q;
    logic        rsp_hs;
    logic [31:0] st_lk_q;
    logic [31:0] st_hit_q;
    logic [31:0] st_dflt_q;

    assign rsp_hs = rsp_v_q && resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_dflt_q <= 1'b0;
            st_lk_q    <= '0;
            st_hit_q   <= '0;
            st_dflt_q  <= '0;
        end else begin
            if (!stall) begin
                rsp_dflt_q <= s2_found_q && (plen_q[s2_idx_q] == 6'd0);
            end
            if (stats_clr) begin
                st_lk_q   <= '0;
                st_hit_q  <= '0;
                st_dflt_q <= '0;
            end else if (rsp_hs) begin
                if (st_lk_q != '1) st_lk_q <= st_lk_q + 32'd1;
                if (rsp_found_q && st_hit_q != '1) st_hit_q <= st_hit_q + 32'd1;
                if (rsp_dflt_q && st_dflt_q != '1) st_dflt_q <= st_dflt_q + 32'd1;
            end
        end
    end

    assign stat_lookups      = st_lk_q;
    assign stat_hits         = st_hit_q;
    assign stat_default_hits = st_dflt_q;
`endif

endmodule
